// File: rtl/traffic_light_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_responder_if
// Description : 2-bit traffic-light command bus between junction controller
//               and lamp responder.
// Revision    : 1.0
// ============================================================================
interface traffic_light_responder_if;
  logic [1:0] cmd;
  logic [1:0] light;
  logic       ack;
  logic       err;
  logic       busy;
  logic       fault;
  logic [3:0] err_cnt;

  modport master (
    output cmd,
    input  light,
    input  ack,
    input  err,
    input  busy,
    input  fault,
    input  err_cnt
  );

  modport slave (
    input  cmd,
    output light,
    output ack,
    output err,
    output busy,
    output fault,
    output err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/traffic_light_responder.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_responder
// Description : Lamp-side endpoint enforcing RED->YEL->GREEN->YEL->RED with
//               per-lamp dwell, error counting and a blinking fault mode.
// Revision    : 1.0
// ============================================================================
module traffic_light_responder #(
  parameter int MIN_DWELL  = 2,
  parameter int MAX_ERR    = 3,
  parameter int BLINK_HALF = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rstb,
  traffic_light_responder_if.slave  bus
);

  localparam int c_dwell_w = (MIN_DWELL < 1)  ? 1 : $clog2(MIN_DWELL + 1);
  localparam int c_blink_w = (BLINK_HALF < 2) ? 1 : $clog2(BLINK_HALF);

  localparam logic [c_dwell_w-1:0] c_dwell_load = c_dwell_w'(MIN_DWELL);
  localparam logic [c_dwell_w-1:0] c_dwell_one  = c_dwell_w'(1);
  localparam logic [c_dwell_w-1:0] c_dwell_zero = '0;
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_HALF - 1);
  localparam logic [c_blink_w-1:0] c_blink_one  = c_blink_w'(1);
  localparam logic [c_blink_w-1:0] c_blink_zero = '0;
  localparam logic [3:0]           c_max_err    = 4'(MAX_ERR);

  localparam logic [1:0] c_lamp_red = 2'b00;
  localparam logic [1:0] c_lamp_yel = 2'b01;
  localparam logic [1:0] c_lamp_grn = 2'b10;

  localparam logic [1:0] c_cmd_nop = 2'b00;
  localparam logic [1:0] c_cmd_yel = 2'b01;
  localparam logic [1:0] c_cmd_grn = 2'b10;
  localparam logic [1:0] c_cmd_red = 2'b11;

  typedef enum logic [2:0] {
    ST_RED    = 3'd0,
    ST_YEL_UP = 3'd1,
    ST_GREEN  = 3'd2,
    ST_YEL_DN = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t               r_state;
  logic [1:0]           r_light;
  logic                 r_ack;
  logic                 r_err;
  logic                 r_fault;
  logic [3:0]           r_err_cnt;
  logic [c_dwell_w-1:0] r_dwell;
  logic [c_blink_w-1:0] r_blink_cnt;

  state_t               w_state_nxt;
  logic [1:0]           w_light_nxt;
  logic                 w_ack_nxt;
  logic                 w_err_nxt;
  logic                 w_fault_nxt;
  logic [3:0]           w_err_cnt_nxt;
  logic [c_dwell_w-1:0] w_dwell_nxt;
  logic [c_blink_w-1:0] w_blink_nxt;

  logic                 w_busy;
  logic [3:0]           w_err_inc;
  logic                 w_legal;

  assign w_busy    = (r_dwell != c_dwell_zero);
  assign w_err_inc = (r_err_cnt == 4'hF) ? 4'hF : (r_err_cnt + 4'd1);

  // RED+RED is legal but keeps the lamp, so it is handled separately below.
  always_comb begin
    w_legal = 1'b0;
    case (r_state)
      ST_RED:    w_legal = (bus.cmd == c_cmd_yel) || (bus.cmd == c_cmd_red);
      ST_YEL_UP: w_legal = (bus.cmd == c_cmd_grn);
      ST_GREEN:  w_legal = (bus.cmd == c_cmd_yel);
      ST_YEL_DN: w_legal = (bus.cmd == c_cmd_red);
      default:   w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_light_nxt   = r_light;
    w_ack_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    w_fault_nxt   = r_fault;
    w_err_cnt_nxt = r_err_cnt;
    w_dwell_nxt   = w_busy ? (r_dwell - c_dwell_one) : c_dwell_zero;
    w_blink_nxt   = r_blink_cnt;

    if (r_state == ST_FAULT) begin
      if (bus.cmd == c_cmd_red) begin
        w_state_nxt   = ST_RED;
        w_light_nxt   = c_lamp_red;
        w_fault_nxt   = 1'b0;
        w_err_cnt_nxt = 4'd0;
        w_ack_nxt     = 1'b1;
        w_dwell_nxt   = c_dwell_load;
        w_blink_nxt   = c_blink_zero;
      end else if (r_blink_cnt == c_blink_last) begin
        w_blink_nxt = c_blink_zero;
        w_light_nxt = (r_light == c_lamp_yel) ? c_lamp_red : c_lamp_yel;
      end else begin
        w_blink_nxt = r_blink_cnt + c_blink_one;
      end
    end else if ((bus.cmd != c_cmd_nop) && !w_busy) begin
      if (w_legal) begin
        w_ack_nxt = 1'b1;
        case (r_state)
          ST_RED: begin
            if (bus.cmd == c_cmd_yel) begin
              w_state_nxt = ST_YEL_UP;
              w_light_nxt = c_lamp_yel;
              w_dwell_nxt = c_dwell_load;
            end
          end
          ST_YEL_UP: begin
            w_state_nxt = ST_GREEN;
            w_light_nxt = c_lamp_grn;
            w_dwell_nxt = c_dwell_load;
          end
          ST_GREEN: begin
            w_state_nxt = ST_YEL_DN;
            w_light_nxt = c_lamp_yel;
            w_dwell_nxt = c_dwell_load;
          end
          ST_YEL_DN: begin
            w_state_nxt = ST_RED;
            w_light_nxt = c_lamp_red;
            w_dwell_nxt = c_dwell_load;
          end
          default: w_state_nxt = r_state;
        endcase
      end else begin
        w_err_nxt     = 1'b1;
        w_err_cnt_nxt = w_err_inc;
        if (w_err_inc >= c_max_err) begin
          w_state_nxt = ST_FAULT;
          w_fault_nxt = 1'b1;
          w_light_nxt = c_lamp_yel;
          w_blink_nxt = c_blink_zero;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= ST_RED;
      r_light     <= c_lamp_red;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_fault     <= 1'b0;
      r_err_cnt   <= 4'd0;
      r_dwell     <= c_dwell_zero;
      r_blink_cnt <= c_blink_zero;
    end else begin
      r_state     <= w_state_nxt;
      r_light     <= w_light_nxt;
      r_ack       <= w_ack_nxt;
      r_err       <= w_err_nxt;
      r_fault     <= w_fault_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_dwell     <= w_dwell_nxt;
      r_blink_cnt <= w_blink_nxt;
    end
  end

  assign bus.light   = r_light;
  assign bus.ack     = r_ack;
  assign bus.err     = r_err;
  assign bus.busy    = w_busy;
  assign bus.fault   = r_fault;
  assign bus.err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/traffic_light_responder.md
Name: traffic_light_responder

Overview:
Light-side endpoint of the 2-bit traffic-light command interface. It receives per-cycle commands from a junction controller and drives the lamp-state code. It enforces the legal lamp sequence RED->YELLOW->GREEN->YELLOW->RED and a minimum dwell time per lamp. Accepted, rejected and ignored commands are signalled back to the controller, and the block enters a blinking fault mode after repeated protocol violations.

Parameters:
MIN_DWELL, 2, cycles after any lamp change during which commands are ignored (0 = never busy)
MAX_ERR, 3, count of illegal commands that triggers FAULT (range 1..15)
BLINK_HALF, 4, cycles per half-period of the fault blink (>=1)

Ports:
clk  input  1  clock
rstb  input  1  reset, asynchronous, active-low
cmd  input  2  00 no-op, 01 go YELLOW, 10 go GREEN, 11 go RED; sampled every posedge
light  output  2  registered lamp code: 00 RED, 01 YELLOW, 10 GREEN (11 never driven)
ack  output  1  registered 1-cycle pulse: command accepted
err  output  1  registered 1-cycle pulse: illegal command rejected
busy  output  1  combinational, equals (dwell counter != 0)
fault  output  1  registered, high while in FAULT
err_cnt  output  4  registered count of illegal commands, saturates at 15

Behaviour:
- Reset (async, any time, including mid-dwell or mid-blink) gives: state RED, light=00, ack=0, err=0, fault=0, err_cnt=0, dwell=0, blink counter=0.
- States: RED, YEL_UP, GREEN, YEL_DN, FAULT. YEL_UP and YEL_DN both drive light=01.
- Legal transitions, applied when cmd is sampled, not busy and not in FAULT:
  - RED + 01 -> YEL_UP
  - YEL_UP + 10 -> GREEN
  - GREEN + 01 -> YEL_DN
  - YEL_DN + 11 -> RED
  - RED + 11 -> stay RED. This is acked, with no dwell reload.
- Latency: the new light value and ack appear together on the same edge, one clock after the cmd setup edge. ack is high for exactly 1 cycle. A cmd held for several cycles is evaluated fresh every cycle against the current state.
- Dwell: on every lamp-changing transition (including entry to RED from FAULT), dwell loads MIN_DWELL. It decrements each cycle while nonzero. Counter width is clog2(MIN_DWELL+1), with a minimum of 1.
- Any cmd other than 00 arriving while busy=1 is ignored: no ack, no err, no count. The controller retries by holding cmd.
- cmd=00 never produces ack or err.
- Illegal command: any non-00 cmd that is not in the legal list, while not busy and not in FAULT.
  - Effect: err pulse for 1 cycle, err_cnt increments (saturating at 15), state and light unchanged.
- FAULT entry: on the edge where the increment makes err_cnt >= MAX_ERR. err pulses that same edge, state becomes FAULT, fault=1, light=01, and the blink counter clears.
- In FAULT:
  - light alternates 01/00, holding each value for BLINK_HALF cycles.
  - cmd 01 and 10 are ignored (no err, no count).
  - cmd 11 in any blink phase gives: state RED, light=00, fault=0, err_cnt=0, ack pulse, dwell=MIN_DWELL.
- Simultaneous events: the dwell decrement and the command evaluation use pre-edge values. On the last busy cycle (dwell=1) a command is still ignored, and the next cycle accepts it.

Test Plan:
- Reset, then hold cmd=01 for 4 cycles (MIN_DWELL=2) -> light goes 00->01 on the first edge with one ack. The held 01 stays ignored while busy, then is flagged illegal in YEL_UP (err=1, err_cnt=1).
- Full legal cycle 01,10,01,11, each held 3 cycles then 00 -> light 00,01,10,01,00. Exactly 4 ack pulses, err_cnt=0.
- From GREEN, cmd=11 with busy=0, three times separated by 00 (MAX_ERR=3) -> err pulses on each. err_cnt goes 1,2,3; fault=1 on the third edge; light=01 and then toggles every 4 cycles.
- In FAULT, cmd 10 for 6 cycles, then 11 for one cycle -> 10 is ignored (err_cnt stays 3). On the 11: light=00, fault=0, err_cnt=0, one ack, busy high for 2 cycles.
- cmd=10 issued the cycle after entering GREEN with MIN_DWELL=2 -> no ack, no err, err_cnt unchanged.
- Assert rstb low mid-dwell in YEL_DN and mid-blink in FAULT -> light=00, fault=0, err_cnt=0, busy=0 immediately, without waiting for a clock edge.
